// File: rtl/minimips_pkg.sv
// Shared MiniMIPS definitions: sequencer state encoding and PC/immediate widths.
package minimips_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int IMM_WIDTH  = 6;
  // Number of copies of the immediate's sign bit needed to reach a full PC word.
  localparam int SEXT_WIDTH = PC_WIDTH - IMM_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC datapath: sequential increment or relative branch target.
module pc_next_logic
  import minimips_pkg::*;
(
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [IMM_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 taken
);

  logic signed [PC_WIDTH-1:0] offset_ext;
  logic        [PC_WIDTH-1:0] seq_pc;
  logic        [PC_WIDTH-1:0] branch_pc;

  // Branch is relative to the following instruction; all sums wrap modulo 2^32.
  always_comb begin
    offset_ext = {{SEXT_WIDTH{branch_offset[IMM_WIDTH-1]}}, branch_offset};
    seq_pc     = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    branch_pc  = seq_pc + $unsigned(offset_ext);
    taken      = branch & zero;
    next_pc    = taken ? branch_pc : seq_pc;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for MiniMIPS: IDLE/RUN/HALT control, PC and retire counter.
module pc_sequencer
  import minimips_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'd0,
  parameter logic [PC_WIDTH-1:0] LAST_PC  = 32'd31
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [IMM_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]  program_counter,
  output logic                 running,
  output logic                 halted,
  output logic [PC_WIDTH-1:0]  retired_count
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] next_pc;
  logic                taken;

  pc_next_logic u_pc_next (
    .pc            (program_counter),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .taken         (taken)
  );

  // Status flags follow the state register directly, so they are mutually exclusive.
  assign running = (state == RUN);
  assign halted  = (state == HALT);

  // Sequencer FSM; stall freezes everything in RUN, reset overrides all inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      program_counter <= RESET_PC;
      retired_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            retired_count <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            retired_count <= retired_count + 32'd1;
            // The final instruction retires and parks the PC unless it branches away.
            if (!taken && (program_counter == LAST_PC)) begin
              state <= HALT;
            end else begin
              program_counter <= next_pc;
            end
          end
        end
        HALT: begin
          if (start) begin
            state           <= RUN;
            program_counter <= RESET_PC;
            retired_count   <= '0;
          end
        end
        default: begin
          state           <= IDLE;
          program_counter <= RESET_PC;
          retired_count   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run vs. a model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: RESET_PC=0, LAST_PC=3
  logic        a_reset = 1'b0, a_start = 1'b0, a_stall = 1'b0;
  logic        a_branch = 1'b0, a_zero = 1'b0;
  logic [5:0]  a_off = 6'd0;
  logic [31:0] a_pc, a_cnt;
  logic        a_run, a_halt;

  // Instance B: wrap-around configuration
  logic        b_reset = 1'b0, b_start = 1'b0, b_stall = 1'b0;
  logic        b_branch = 1'b0, b_zero = 1'b0;
  logic [5:0]  b_off = 6'd0;
  logic [31:0] b_pc, b_cnt;
  logic        b_run, b_halt;

  pc_sequencer #(.RESET_PC(32'd0), .LAST_PC(32'd3)) dut_a (
    .clock(clk), .reset(a_reset), .start(a_start), .stall(a_stall),
    .branch(a_branch), .zero(a_zero), .branch_offset(a_off),
    .program_counter(a_pc), .running(a_run), .halted(a_halt),
    .retired_count(a_cnt)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFE), .LAST_PC(32'd1)) dut_b (
    .clock(clk), .reset(b_reset), .start(b_start), .stall(b_stall),
    .branch(b_branch), .zero(b_zero), .branch_offset(b_off),
    .program_counter(b_pc), .running(b_run), .halted(b_halt),
    .retired_count(b_cnt)
  );

  // Behavioural model of instance A: mode 0=idle, 1=run, 2=halt
  localparam logic [31:0] A_RESET = 32'd0;
  localparam logic [31:0] A_LAST  = 32'd3;
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'd0;
  logic [31:0] m_cnt  = 32'd0;

  task automatic model_step();
    int off_i;
    off_i = $signed(a_off);
    if (a_reset) begin
      m_mode = 0; m_pc = A_RESET; m_cnt = 32'd0;
    end else if (m_mode == 0) begin
      if (a_start) begin m_mode = 1; m_cnt = 32'd0; end
    end else if (m_mode == 1) begin
      if (!a_stall) begin
        m_cnt = m_cnt + 32'd1;
        if (a_branch && a_zero) m_pc = m_pc + 32'd1 + 32'(off_i);
        else if (m_pc == A_LAST) m_mode = 2;
        else m_pc = m_pc + 32'd1;
      end
    end else begin
      if (a_start) begin m_mode = 1; m_pc = A_RESET; m_cnt = 32'd0; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_reset = 1'b1; a_start = 1'b0; a_stall = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
    tick();
    a_reset = 1'b0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    a_start = 1'b1; a_stall = 1'b1; a_branch = 1'b1; a_zero = 1'b1;
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_start = 1'b0; a_stall = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
    total++; if (a_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=%h", a_pc, 32'd0); end
    total++; if (a_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", a_cnt); end
    total++; if (a_run !== 1'b0 || a_halt !== 1'b0) begin bad++; $display("FAIL reset_flags got run=%b halt=%b want 0 0", a_run, a_halt); end
    // IDLE holds the PC with no start
    a_branch = 1'b1; a_zero = 1'b1; a_off = 6'd5;
    tick(); tick();
    a_branch = 1'b0; a_zero = 1'b0;
    total++; if (a_pc !== 32'd0 || a_run !== 1'b0) begin bad++; $display("FAIL idle_hold got pc=%h run=%b want 0 0", a_pc, a_run); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_seq [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
    reset_a();
    start_a();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_pc !== exp_seq[i] || a_run !== 1'b1) begin
        bad++; $display("FAIL seq_pc%0d got pc=%h run=%b want pc=%h run=1", i, a_pc, a_run, exp_seq[i]);
      end
      tick();
    end
    total++; if (a_halt !== 1'b1 || a_run !== 1'b0) begin bad++; $display("FAIL seq_halt got halt=%b run=%b want 1 0", a_halt, a_run); end
    total++; if (a_cnt !== 32'd4) begin bad++; $display("FAIL seq_cnt got=%0d want=4", a_cnt); end
    tick(); tick();
    total++; if (a_pc !== 32'd3 || a_cnt !== 32'd4) begin bad++; $display("FAIL halt_hold got pc=%h cnt=%0d want 3 4", a_pc, a_cnt); end
  endtask

  task automatic test_branch();
    reset_a();
    start_a();
    a_branch = 1'b1; a_zero = 1'b1; a_off = 6'd4; tick();
    total++; if (a_pc !== 32'd5) begin bad++; $display("FAIL br_to5 got=%h want=5", a_pc); end
    a_off = 6'b111110; tick();
    total++; if (a_pc !== 32'd4) begin bad++; $display("FAIL br_neg2 got=%h want=4", a_pc); end
    a_branch = 1'b0; tick();
    a_branch = 1'b1; a_off = 6'b000011; tick();
    total++; if (a_pc !== 32'd9) begin bad++; $display("FAIL br_pos3 got=%h want=9", a_pc); end
    a_off = 6'b111011; tick();
    total++; if (a_pc !== 32'd5) begin bad++; $display("FAIL br_neg5 got=%h want=5", a_pc); end
    a_zero = 1'b0; a_off = 6'b011111; tick();
    total++; if (a_pc !== 32'd6) begin bad++; $display("FAIL br_notaken got=%h want=6", a_pc); end
    total++; if (a_cnt !== 32'd6) begin bad++; $display("FAIL br_cnt got=%0d want=6", a_cnt); end
    a_branch = 1'b0;
  endtask

  task automatic test_stall();
    reset_a();
    start_a();
    tick(); tick();
    a_stall = 1'b1; a_branch = 1'b1; a_zero = 1'b1; a_off = 6'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (a_pc !== 32'd2 || a_cnt !== 32'd2 || a_run !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got pc=%h cnt=%0d run=%b want 2 2 1", i, a_pc, a_cnt, a_run);
      end
    end
    a_stall = 1'b0; tick();
    a_branch = 1'b0; a_zero = 1'b0;
    total++; if (a_pc !== 32'd6 || a_cnt !== 32'd3) begin bad++; $display("FAIL stall_release got pc=%h cnt=%0d want 6 3", a_pc, a_cnt); end
  endtask

  task automatic test_reset_mid_run();
    reset_a();
    start_a();
    a_branch = 1'b1; a_zero = 1'b1; a_off = 6'd6; tick();
    total++; if (a_pc !== 32'd7) begin bad++; $display("FAIL mid_setup got=%h want=7", a_pc); end
    a_reset = 1'b1; a_start = 1'b1; tick();
    a_reset = 1'b0; a_start = 1'b0;
    total++; if (a_pc !== 32'd0 || a_cnt !== 32'd0 || a_run !== 1'b0 || a_halt !== 1'b0) begin
      bad++; $display("FAIL mid_reset got pc=%h cnt=%0d run=%b halt=%b want 0 0 0 0", a_pc, a_cnt, a_run, a_halt);
    end
    for (int i = 0; i < 4; i++) begin
      a_off = 6'($urandom); tick();
    end
    a_branch = 1'b0; a_zero = 1'b0;
    total++; if (a_pc !== 32'd0 || a_run !== 1'b0) begin bad++; $display("FAIL mid_idle got pc=%h run=%b want 0 0", a_pc, a_run); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    b_reset = 1'b1; tick(); b_reset = 1'b0;
    total++; if (b_pc !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_reset got=%h want=fffffffe", b_pc); end
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (b_pc !== exp_seq[i]) begin bad++; $display("FAIL wrap_pc%0d got=%h want=%h", i, b_pc, exp_seq[i]); end
      tick();
    end
    total++; if (b_halt !== 1'b1 || b_pc !== 32'd1 || b_cnt !== 32'd4) begin
      bad++; $display("FAIL wrap_halt got halt=%b pc=%h cnt=%0d want 1 1 4", b_halt, b_pc, b_cnt);
    end
  endtask

  task automatic test_restart();
    reset_a();
    start_a();
    for (int i = 0; i < 4; i++) tick();
    total++; if (a_halt !== 1'b1) begin bad++; $display("FAIL restart_pre got halt=%b want 1", a_halt); end
    start_a();
    total++; if (a_pc !== 32'd0 || a_cnt !== 32'd0 || a_run !== 1'b1 || a_halt !== 1'b0) begin
      bad++; $display("FAIL restart got pc=%h cnt=%0d run=%b halt=%b want 0 0 1 0", a_pc, a_cnt, a_run, a_halt);
    end
    tick();
    start_a();
    total++; if (a_pc !== 32'd2 || a_cnt !== 32'd2 || a_run !== 1'b1) begin
      bad++; $display("FAIL start_in_run got pc=%h cnt=%0d run=%b want 2 2 1", a_pc, a_cnt, a_run);
    end
  endtask

  task automatic test_random();
    reset_a();
    for (int i = 0; i < 400; i++) begin
      a_reset  = ($urandom_range(0, 49) == 0);
      a_start  = ($urandom_range(0, 5) == 0);
      a_stall  = ($urandom_range(0, 3) == 0);
      a_branch = $urandom_range(0, 1) == 1;
      a_zero   = $urandom_range(0, 1) == 1;
      a_off    = 6'($urandom);
      tick();
      total++;
      if (a_pc !== m_pc || a_cnt !== m_cnt || a_run !== (m_mode == 1) || a_halt !== (m_mode == 2)) begin
        bad++;
        $display("FAIL rand%0d got pc=%h cnt=%0d run=%b halt=%b want pc=%h cnt=%0d mode=%0d",
                 i, a_pc, a_cnt, a_run, a_halt, m_pc, m_cnt, m_mode);
      end
      total++;
      if (a_run && a_halt) begin bad++; $display("FAIL rand_flags%0d got run=1 halt=1 want exclusive", i); end
    end
    a_reset = 1'b0; a_start = 1'b0; a_stall = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sequence();
    test_branch();
    test_stall();
    test_reset_mid_run();
    test_wrap();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
